binary_to_bcd_seq: RTL and testbench
====================================

Name: binary_to_bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using double-dabble, one input bit per clock.
- Valid/ready handshakes on both input and output, so it can sit between streaming blocks and a display or formatting stage.
- Also reports the count of significant decimal digits, for leading-zero blanking downstream.
- Successor to the 5-bit combinational converter: arbitrary width, registered, flow-controlled.

Parameters:
- BIN_W, 16, width of the binary input in bits (legal range 1..32).
- DIGITS, 5, number of BCD digits in the output. Must satisfy 10^DIGITS > 2^BIN_W - 1; otherwise elaboration fails with $error.
- NDIG_W, $clog2(DIGITS+1), width of the significant-digit count (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a new operand
- in_data  in  BIN_W  unsigned binary operand
- out_valid  out  1  out_bcd / out_ndig are valid
- out_ready  in  1  consumer accepts the result
- out_bcd  out  4*DIGITS  packed BCD; digit k in bits [4k+3:4k], digit 0 = ones
- out_ndig  out  NDIG_W  significant digits, 1..DIGITS (value 0 reports 1)
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_bcd=0, out_ndig=1, busy=0.
  - Shift register and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the shift register, clear the BCD accumulator, load bit counter = BIN_W-1, go to SHIFT.
  - in_data is sampled only on the accept edge.
- SHIFT:
  - in_ready=0.
  - Each cycle, first add 3 to every accumulator digit >= 5.
  - Then shift {accumulator, shift register} left by 1, so the binary MSB enters digit 0 bit 0.
  - Decrement the counter. When it is 0, go to DONE on the same edge.
  - Exactly BIN_W SHIFT cycles per operand.
- DONE:
  - out_valid=1.
  - out_bcd and out_ndig come from registers and are stable while out_valid=1.
  - out_ndig = index of the highest nonzero digit + 1, or 1 if all digits are zero. Computed combinationally from the final accumulator and registered on entry to DONE.
  - On out_valid&&out_ready: go to IDLE. out_valid drops next cycle. out_bcd holds its last value until the next DONE.
- Latency: out_valid rises BIN_W+1 clock edges after the accept edge (BIN_W=16: 17 cycles).
- Throughput: at most one operand per BIN_W+2 cycles. No overlap of accept with DONE.
- Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0 during the hold.
- Arithmetic:
  - Unsigned only.
  - Add-3 is applied per 4-bit digit, with no carry between digits.
  - Digits above the highest reachable one stay 0.
- out_ready while out_valid=0: ignored. in_valid while in_ready=0: ignored; the operand is not queued.
- Reset mid-SHIFT or mid-DONE: conversion is abandoned and all outputs return to reset values immediately (asynchronously).
- Edge cases BIN_W=1 and DIGITS=1: latency 2, ndig always 1.

Test Plan:
- Exhaustive sweep, BIN_W=5 DIGITS=2: in_data 0..31 each, out_ready=1 -> out_bcd == {n/10, n%10}, latency exactly 6 edges, out_ndig=1 for n<10 and 2 otherwise.
- Default params, in_data=16'hFFFF -> out_bcd=20'h65535, out_ndig=5. in_data=0 -> out_bcd=0, out_ndig=1. in_data=1000 -> 20'h01000, out_ndig=4.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid with in_data=12345 -> out_bcd=20'h12345 stable, in_ready=0 throughout. Release -> out_valid falls next cycle, in_ready=1.
- Back-to-back: in_valid held high with operands 9, 10, 99 -> three results 0x00009, 0x00010, 0x00099, accepts spaced exactly 18 cycles apart, no operand lost or duplicated.
- Reset mid-conversion: assert rst_n=0 at 8th SHIFT cycle of operand 54321 -> out_valid=0, out_bcd=0, in_ready=1 without waiting for a clock. After release, operand 42 -> 20'h00042.
- Ignored stimulus: toggle in_valid/in_data during SHIFT and pulse out_ready while out_valid=0 -> result equals the originally accepted operand, no spurious out_valid.

Source files
------------

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq
//   Sequential double-dabble binary-to-BCD converter, one input bit per clock,
//   with valid/ready handshakes on the operand and result sides. Also reports
//   the number of significant decimal digits for leading-zero blanking.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   block can accept a new operand (IDLE)
//   in_data    unsigned binary operand, BIN_W bits
//   out_valid  out_bcd / out_ndig are valid (DONE)
//   out_ready  consumer accepts the result
//   out_bcd    packed BCD, digit k in [4k+3:4k], digit 0 = ones
//   out_ndig   significant digit count, 1..DIGITS (zero reports 1)
//   busy       high while converting or holding a result
module binary_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int NDIG_W = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [NDIG_W-1:0]     out_ndig,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // Decimal digits needed for the largest BIN_W-bit value.
  function automatic int unsigned digits_needed(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
    $error("binary_to_bcd_seq: BIN_W must be in 1..32");
  end
  if (DIGITS < int'(digits_needed(BIN_W))) begin : g_bad_digits
    $error("binary_to_bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sr_q;
  logic [BCD_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [NDIG_W-1:0]  ndig_q;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic [NDIG_W-1:0]  ndig_next;

  // Add-3 correction per digit (no inter-digit carry), then shift the
  // binary MSB into digit 0 bit 0.
  always_comb begin
    acc_adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      else                         acc_adj[4*k +: 4] = acc_q[4*k +: 4];
    end
    acc_shift = {acc_adj[BCD_W-2:0], sr_q[BIN_W-1]};
  end

  // Significant digits of the value about to be latched into DONE.
  always_comb begin
    ndig_next = NDIG_W'(1);
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (acc_shift[4*k +: 4] != 4'd0) ndig_next = NDIG_W'(k + 1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = SHIFT;
      SHIFT:   if (cnt_q == '0)    state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_bcd   = bcd_q;
    out_ndig  = ndig_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      ndig_q <= NDIG_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q  <= in_data;
            acc_q <= '0;
            cnt_q <= CNT_W'(BIN_W - 1);
          end
        end
        SHIFT: begin
          sr_q  <= sr_q << 1;
          acc_q <= acc_shift;
          cnt_q <= cnt_q - 1'b1;
          // Result registers load only on the DONE entry edge so they stay
          // stable through DONE and hold afterwards.
          if (cnt_q == '0) begin
            bcd_q  <= acc_shift;
            ndig_q <= ndig_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Testbench for binary_to_bcd_seq: a default-parameter instance driven by a
// vector table plus multi-cycle sequences, and a BIN_W=5/DIGITS=2 instance
// swept over all inputs.
module tb_binary_to_bcd_seq;

  logic clk;
  logic rst_n;

  // Default instance (BIN_W=16, DIGITS=5)
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data;
  logic [19:0] out_bcd;
  logic [2:0]  out_ndig;

  // Small instance (BIN_W=5, DIGITS=2)
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [4:0]  s_in_data;
  logic [7:0]  s_out_bcd;
  logic [1:0]  s_out_ndig;

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_ndig(out_ndig), .busy(busy)
  );

  binary_to_bcd_seq #(.BIN_W(5), .DIGITS(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_bcd(s_out_bcd), .out_ndig(s_out_ndig), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept and result log for the default instance, sampled mid-cycle.
  int          cyc = 0;
  int          acc_cyc[$];
  logic [19:0] res_q[$];
  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready)   acc_cyc.push_back(cyc);
    if (out_valid && out_ready) res_q.push_back(out_bcd);
  end

  // One full transaction on the default instance. lat counts clock edges
  // from the accept edge (inclusive) until out_valid is seen.
  task automatic convert(input logic [15:0] d, input bit noisy,
                         output logic [19:0] bcd, output logic [2:0] ndig, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin step(); guard++; end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    step();
    lat = 1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    while (!out_valid && lat < 100) begin
      if (noisy) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 16'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    in_valid  = 1'b0;
    in_data   = '0;
    bcd       = out_bcd;
    ndig      = out_ndig;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_after_done", in_ready, 1);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [19:0] bcd;
    logic [2:0]  ndig;
  } vec_t;

  vec_t        vecs[9];
  logic [19:0] r_bcd;
  logic [2:0]  r_ndig;
  int          r_lat;
  logic [15:0] ops[3];
  bit          stable_ok, ready_low_ok;
  int          a0, r0, guard, lat;

  initial begin
    vecs[0] = '{16'hFFFF, 20'h65535, 3'd5};
    vecs[1] = '{16'd0,    20'h00000, 3'd1};
    vecs[2] = '{16'd1000, 20'h01000, 3'd4};
    vecs[3] = '{16'd9,    20'h00009, 3'd1};
    vecs[4] = '{16'd10,   20'h00010, 3'd2};
    vecs[5] = '{16'd100,  20'h00100, 3'd3};
    vecs[6] = '{16'd9999, 20'h09999, 3'd4};
    vecs[7] = '{16'd12345,20'h12345, 3'd5};
    vecs[8] = '{16'd65530,20'h65530, 3'd5};
    ops[0] = 16'd9; ops[1] = 16'd10; ops[2] = 16'd99;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bcd",   out_bcd, 0);
    check("rst_out_ndig",  out_ndig, 1);
    check("rst_busy",      busy, 0);
    check("rst_s_in_ready", s_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven vectors, default parameters
    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].din, 1'b0, r_bcd, r_ndig, r_lat);
      check($sformatf("vec%0d_bcd", i),  r_bcd,  vecs[i].bcd);
      check($sformatf("vec%0d_ndig", i), r_ndig, vecs[i].ndig);
      check($sformatf("vec%0d_lat", i),  r_lat,  17);
    end

    // Exhaustive sweep of the 5-bit instance, out_ready held high
    for (int n = 0; n < 32; n++) begin
      check("s_in_ready", s_in_ready, 1);
      s_in_valid = 1'b1;
      s_in_data  = 5'(n);
      step();
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 50) begin step(); lat++; end
      check($sformatf("sweep%0d_bcd", n),  s_out_bcd, {4'(n / 10), 4'(n % 10)});
      check($sformatf("sweep%0d_ndig", n), s_out_ndig, (n < 10) ? 1 : 2);
      check($sformatf("sweep%0d_lat", n),  lat, 6);
      step();
    end

    // Backpressure: hold the result for 20 cycles
    in_valid = 1'b1; in_data = 16'd12345;
    step();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin step(); guard++; end
    check("bp_out_valid", out_valid, 1);
    stable_ok = 1'b1; ready_low_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      if (out_bcd != 20'h12345 || !out_valid || out_ndig != 3'd5) stable_ok = 1'b0;
      if (in_ready) ready_low_ok = 1'b0;
      step();
    end
    in_valid = 1'b0;
    check("bp_result_stable", stable_ok, 1);
    check("bp_in_ready_low", ready_low_ok, 1);
    check("bp_bcd", out_bcd, 20'h12345);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_bcd_held", out_bcd, 20'h12345);

    // Back-to-back with in_valid held high
    a0 = acc_cyc.size();
    r0 = res_q.size();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = ops[i];
      guard = 0;
      do begin step(); guard++; end while (acc_cyc.size() < a0 + i + 1 && guard < 100);
    end
    in_valid = 1'b0;
    guard = 0;
    while (res_q.size() < r0 + 3 && guard < 100) begin step(); guard++; end
    repeat (5) step();
    out_ready = 1'b0;
    check("b2b_accepts", acc_cyc.size() - a0, 3);
    check("b2b_results", res_q.size() - r0, 3);
    if (acc_cyc.size() >= a0 + 3 && res_q.size() >= r0 + 3) begin
      check("b2b_res0", res_q[r0],     20'h00009);
      check("b2b_res1", res_q[r0 + 1], 20'h00010);
      check("b2b_res2", res_q[r0 + 2], 20'h00099);
      check("b2b_gap01", acc_cyc[a0 + 1] - acc_cyc[a0],     18);
      check("b2b_gap12", acc_cyc[a0 + 2] - acc_cyc[a0 + 1], 18);
    end

    // Reset in the middle of a conversion
    in_valid = 1'b1; in_data = 16'd54321;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_bcd",   out_bcd, 0);
    check("arst_out_ndig",  out_ndig, 1);
    check("arst_in_ready",  in_ready, 1);
    check("arst_busy",      busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    convert(16'd42, 1'b0, r_bcd, r_ndig, r_lat);
    check("post_rst_bcd",  r_bcd,  20'h00042);
    check("post_rst_ndig", r_ndig, 2);
    check("post_rst_lat",  r_lat,  17);

    // Noise on in_valid/in_data/out_ready while converting
    convert(16'd777, 1'b1, r_bcd, r_ndig, r_lat);
    check("noisy_bcd",  r_bcd,  20'h00777);
    check("noisy_ndig", r_ndig, 3);
    check("noisy_lat",  r_lat,  17);
    out_ready = 1'b1;
    repeat (3) step();
    check("noisy_no_spurious_valid", out_valid, 0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
